// File: rtl/yuv_reader_pkg.sv
// Shared types and constants for the planar YUV 4:2:0 frame reader.
// Holds the FSM state enum, group geometry and default plane bases.
package yuv_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM
  } state_e;

  localparam int GROUP_PIX       = 16;
  localparam int WORDS_PER_GROUP = 4;

  function automatic int def_u_base(input int w, input int h);
    return w * h / 8;
  endfunction

  function automatic int def_v_base(input int w, input int h);
    return def_u_base(w, h) + w * h / 32;
  endfunction

endpackage

// File: rtl/yuv_frame_reader_group_buffer.sv
// One 16-pixel group: Y0/Y1/U/V words, byte-selected by column.
// Ports: clk, rst_n, wr_en/wr_idx/wr_data, col -> y, u, v.
module yuv_group_buffer
  import yuv_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic [63:0] wr_data,
  input  logic [3:0]  col,
  output logic [7:0]  y,
  output logic [7:0]  u,
  output logic [7:0]  v
);

  logic [63:0] word_q [WORDS_PER_GROUP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_GROUP; i++)
        word_q[i] <= '0;
    end else if (wr_en) begin
      word_q[wr_idx] <= wr_data;
    end
  end

  // Chroma byte index is col/2: one sample per column pair.
  assign y = word_q[{1'b0, col[3]}][{col[2:0], 3'b000} +: 8];
  assign u = word_q[2][{col[3:1], 3'b000} +: 8];
  assign v = word_q[3][{col[3:1], 3'b000} +: 8];

endmodule

// File: rtl/yuv_frame_reader.sv
// Planar YUV 4:2:0 frame reader: fetches 16-pixel groups, streams pixels.
// Ports: CLOCK2_50, RESET_N, start/busy/frame_done, rden/rdaddress/q, pix_*.
// Option: YUV_READER_PREFETCH_EN adds a second buffer for gapless output.
module yuv_frame_reader
  import yuv_reader_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int Y_BASE = 0,
  parameter int U_BASE = def_u_base(WIDTH, HEIGHT),
  parameter int V_BASE = def_v_base(WIDTH, HEIGHT)
) (
  input  logic        CLOCK2_50,
  input  logic        RESET_N,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        rden,
  output logic [15:0] rdaddress,
  input  logic [63:0] q,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_y,
  output logic [7:0]  pix_u,
  output logic [7:0]  pix_v,
  output logic        pix_sof,
  output logic        pix_eol
);

  localparam int GPL = WIDTH / GROUP_PIX;
  localparam int GW  = (GPL > 1) ? $clog2(GPL) : 1;
  localparam int RW  = $clog2(HEIGHT);
  localparam logic [GW-1:0] LAST_GRP = GW'(GPL - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [3:0]    LAST_COL = 4'(GROUP_PIX - 1);
  localparam logic [15:0]   YB = 16'(Y_BASE);
  localparam logic [15:0]   UB = 16'(U_BASE);
  localparam logic [15:0]   VB = 16'(V_BASE);
  localparam logic [15:0]   YSTRIDE = 16'(WIDTH / 8);
  localparam logic [15:0]   CSTRIDE = 16'(WIDTH / 16);

  function automatic logic [15:0] grp_addr(
    input logic [RW-1:0] r,
    input logic [GW-1:0] g,
    input logic [1:0]    idx
  );
    logic [15:0] yrow, crow, g16;
    yrow = 16'(r) * YSTRIDE;
    crow = 16'(r >> 1) * CSTRIDE;
    g16  = 16'(g);
    case (idx)
      2'd0:    grp_addr = YB + yrow + {g16[14:0], 1'b0};
      2'd1:    grp_addr = YB + yrow + {g16[14:0], 1'b0} + 16'd1;
      2'd2:    grp_addr = UB + crow + g16;
      default: grp_addr = VB + crow + g16;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    iss_q, iss_d;
  logic          busy_q, busy_d;
  logic          fd_q, fd_d;
  logic          rden_q, rden_d;
  logic [15:0]   addr_q, addr_d;
  logic [1:0]    ridx_q, ridx_d;
  logic          cap_v_q, cap_v_d;
  logic [1:0]    cap_idx_q, cap_idx_d;
  logic          vld_q, vld_d;

  logic          hs, grp_end, frame_end, last_grp, last_row;
  logic          cap_last;
  logic [GW-1:0] nxt_grp;
  logic [RW-1:0] nxt_row;
  logic [7:0]    sel_y, sel_u, sel_v;

`ifdef YUV_READER_PREFETCH_EN
  logic          cur_q, cur_d;
  logic          rbuf_q, rbuf_d;
  logic          cap_buf_q, cap_buf_d;
  logic [2:0]    pf_idx_q, pf_idx_d;
  logic          pf_full_q, pf_full_d;
  logic          pf_cap, pf_ok;
  logic [7:0]    y0, u0, v0, y1, u1, v1;
`endif

  assign hs        = vld_q & pix_ready;
  assign last_grp  = grp_q == LAST_GRP;
  assign last_row  = row_q == LAST_ROW;
  assign grp_end   = hs & (col_q == LAST_COL);
  assign frame_end = grp_end & last_grp & last_row;
  assign nxt_grp   = last_grp ? '0 : grp_q + GW'(1);
  assign nxt_row   = last_grp ? row_q + RW'(1) : row_q;

`ifdef YUV_READER_PREFETCH_EN
  assign cap_last = cap_v_q & (cap_idx_q == 2'd3)
                  & (cap_buf_q == cur_q);
  // Prefetch complete now or earlier: safe to swap at group end.
  assign pf_cap   = cap_v_q & (cap_idx_q == 2'd3)
                  & (cap_buf_q != cur_q);
  assign pf_ok    = pf_full_q | pf_cap;
`else
  assign cap_last = cap_v_q & (cap_idx_q == 2'd3);
`endif

  always_ff @(posedge CLOCK2_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      grp_q     <= '0;
      col_q     <= '0;
      iss_q     <= '0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      rden_q    <= 1'b0;
      addr_q    <= '0;
      ridx_q    <= '0;
      cap_v_q   <= 1'b0;
      cap_idx_q <= '0;
      vld_q     <= 1'b0;
`ifdef YUV_READER_PREFETCH_EN
      cur_q     <= 1'b0;
      rbuf_q    <= 1'b0;
      cap_buf_q <= 1'b0;
      pf_idx_q  <= '0;
      pf_full_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      grp_q     <= grp_d;
      col_q     <= col_d;
      iss_q     <= iss_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
      rden_q    <= rden_d;
      addr_q    <= addr_d;
      ridx_q    <= ridx_d;
      cap_v_q   <= cap_v_d;
      cap_idx_q <= cap_idx_d;
      vld_q     <= vld_d;
`ifdef YUV_READER_PREFETCH_EN
      cur_q     <= cur_d;
      rbuf_q    <= rbuf_d;
      cap_buf_q <= cap_buf_d;
      pf_idx_q  <= pf_idx_d;
      pf_full_q <= pf_full_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (iss_q == 2'd3) state_d = S_WAIT;
      S_WAIT:  if (cap_last) state_d = S_STREAM;
      S_STREAM: begin
        if (frame_end)
          state_d = S_IDLE;
        else if (grp_end)
`ifdef YUV_READER_PREFETCH_EN
          state_d = pf_ok ? S_STREAM : S_WAIT;
`else
          state_d = S_FETCH;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_d     = row_q;
    grp_d     = grp_q;
    col_d     = col_q;
    iss_d     = iss_q;
    busy_d    = busy_q;
    fd_d      = 1'b0;
    rden_d    = 1'b0;
    addr_d    = addr_q;
    ridx_d    = ridx_q;
    vld_d     = vld_q;
    cap_v_d   = rden_q;
    cap_idx_d = ridx_q;
`ifdef YUV_READER_PREFETCH_EN
    cur_d     = cur_q;
    rbuf_d    = rbuf_q;
    cap_buf_d = rbuf_q;
    pf_idx_d  = pf_idx_q;
    pf_full_d = pf_full_q | pf_cap;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          row_d  = '0;
          grp_d  = '0;
          col_d  = '0;
          rden_d = 1'b1;
          addr_d = grp_addr('0, '0, 2'd0);
          ridx_d = 2'd0;
          iss_d  = 2'd1;
`ifdef YUV_READER_PREFETCH_EN
          cur_d     = 1'b0;
          rbuf_d    = 1'b0;
          pf_idx_d  = '0;
          pf_full_d = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        rden_d = 1'b1;
        addr_d = grp_addr(row_q, grp_q, iss_q);
        ridx_d = iss_q;
        iss_d  = iss_q + 2'd1;
      end
      S_WAIT: begin
        if (cap_last) begin
          vld_d = 1'b1;
          col_d = '0;
        end
      end
      S_STREAM: begin
        if (hs) col_d = col_q + 4'd1;
        if (grp_end) begin
          grp_d = nxt_grp;
          row_d = nxt_row;
        end
        if (frame_end) begin
          vld_d  = 1'b0;
          busy_d = 1'b0;
          fd_d   = 1'b1;
        end else if (grp_end) begin
`ifdef YUV_READER_PREFETCH_EN
          vld_d     = pf_ok;
          cur_d     = ~cur_q;
          pf_idx_d  = '0;
          pf_full_d = 1'b0;
`else
          // Refill starts on the handshake edge itself.
          vld_d  = 1'b0;
          rden_d = 1'b1;
          addr_d = grp_addr(nxt_row, nxt_grp, 2'd0);
          ridx_d = 2'd0;
          iss_d  = 2'd1;
`endif
        end
`ifdef YUV_READER_PREFETCH_EN
        else if (!(last_grp & last_row) && pf_idx_q < 3'd4) begin
          rden_d   = 1'b1;
          addr_d   = grp_addr(nxt_row, nxt_grp, pf_idx_q[1:0]);
          ridx_d   = pf_idx_q[1:0];
          rbuf_d   = ~cur_q;
          pf_idx_d = pf_idx_q + 3'd1;
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef YUV_READER_PREFETCH_EN
  yuv_group_buffer u_buf0 (
    .clk     (CLOCK2_50),
    .rst_n   (RESET_N),
    .wr_en   (cap_v_q & ~cap_buf_q),
    .wr_idx  (cap_idx_q),
    .wr_data (q),
    .col     (col_q),
    .y       (y0),
    .u       (u0),
    .v       (v0)
  );

  yuv_group_buffer u_buf1 (
    .clk     (CLOCK2_50),
    .rst_n   (RESET_N),
    .wr_en   (cap_v_q & cap_buf_q),
    .wr_idx  (cap_idx_q),
    .wr_data (q),
    .col     (col_q),
    .y       (y1),
    .u       (u1),
    .v       (v1)
  );

  assign sel_y = cur_q ? y1 : y0;
  assign sel_u = cur_q ? u1 : u0;
  assign sel_v = cur_q ? v1 : v0;
`else
  yuv_group_buffer u_buf0 (
    .clk     (CLOCK2_50),
    .rst_n   (RESET_N),
    .wr_en   (cap_v_q),
    .wr_idx  (cap_idx_q),
    .wr_data (q),
    .col     (col_q),
    .y       (sel_y),
    .u       (sel_u),
    .v       (sel_v)
  );
`endif

  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign rden       = rden_q;
  assign rdaddress  = addr_q;
  assign pix_valid  = vld_q;
  assign pix_y      = vld_q ? sel_y : 8'd0;
  assign pix_u      = vld_q ? sel_u : 8'd0;
  assign pix_v      = vld_q ? sel_v : 8'd0;
  assign pix_sof    = vld_q & (row_q == '0) & (grp_q == '0)
                    & (col_q == 4'd0);
  assign pix_eol    = vld_q & last_grp & (col_q == LAST_COL);

endmodule

// File: tb/tb_yuv_frame_reader.sv
// Self-checking bench for yuv_frame_reader at 32x4 with a 1-cycle memory.
// Pixel/address model derived from frame coordinates, plus literal pins.
module tb_yuv_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        busy, frame_done, rden;
  logic [15:0] rdaddress;
  logic [63:0] q = '0;
  logic        pix_valid, pix_sof, pix_eol;
  logic [7:0]  pix_y, pix_u, pix_v;

  int          errors = 0;
  int          checks = 0;
  int          pix_k = 0;
  int          rd_k = 0;
  logic        all_ready = 1'b0;
  logic [15:0] rd_log [32];

  always #5 clk = ~clk;

  yuv_frame_reader #(.WIDTH(32), .HEIGHT(4)) dut (
    .CLOCK2_50  (clk),
    .RESET_N    (rst_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .rden       (rden),
    .rdaddress  (rdaddress),
    .q          (q),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_y      (pix_y),
    .pix_u      (pix_u),
    .pix_v      (pix_v),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol)
  );

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    logic [63:0] w;
    int b;
    for (int i = 0; i < 8; i++) begin
      b = (int'(a) * 8 + i) % 256;
      w[i*8 +: 8] = b[7:0];
    end
    return w;
  endfunction

  always @(posedge clk)
    if (rden) q <= mem_word(rdaddress);

  // Pixel k of the frame in raster order: {sof, eol, y, u, v}.
  function automatic logic [25:0] exp_pix(input int k);
    int r, x, y, u, v;
    r = k / 32;
    x = k % 32;
    y = (r * 32 + x) % 256;
    u = ((16 + (r / 2) * 2 + x / 16) * 8 + (x % 16) / 2) % 256;
    v = ((20 + (r / 2) * 2 + x / 16) * 8 + (x % 16) / 2) % 256;
    return {k == 0, x == 31, y[7:0], u[7:0], v[7:0]};
  endfunction

  // Read n of the frame: group n/4 in raster order, word n%4.
  function automatic logic [15:0] exp_addr(input int n);
    int g, j, r, gp, a;
    g  = n / 4;
    j  = n % 4;
    r  = g / 2;
    gp = g % 2;
    case (j)
      0:       a = r * 4 + 2 * gp;
      1:       a = r * 4 + 2 * gp + 1;
      2:       a = 16 + (r / 2) * 2 + gp;
      default: a = 20 + (r / 2) * 2 + gp;
    endcase
    return a[15:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic        hs, stall, exp_fd;
    logic [25:0] snap;
    hs     = pix_valid & pix_ready;
    stall  = pix_valid & ~pix_ready;
    snap   = {pix_sof, pix_eol, pix_y, pix_u, pix_v};
    exp_fd = 1'b0;
    if (rst_n) begin
      if (hs) begin
        chk($sformatf("pixel%0d", pix_k), 64'(snap), 64'(exp_pix(pix_k)));
        exp_fd = (pix_k == 127);
        pix_k  = exp_fd ? 0 : pix_k + 1;
      end
      if (rden) begin
        chk($sformatf("rdaddr%0d", rd_k), 64'(rdaddress),
            64'(exp_addr(rd_k)));
        rd_log[rd_k] = rdaddress;
        rd_k = (rd_k + 1) % 32;
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("frame_done", 64'(frame_done), 64'(exp_fd));
      if (exp_fd) chk("busy_at_done", 64'(busy), 64'd0);
      if (stall)
        chk("stall_hold",
            64'({pix_valid, pix_sof, pix_eol, pix_y, pix_u, pix_v}),
            64'({1'b1, snap}));
`ifdef YUV_READER_PREFETCH_EN
      if (all_ready && pix_k != 0) chk("gapless", 64'(pix_valid), 64'd1);
`endif
    end
  endtask

  task automatic run_frame(input logic rnd);
    int n;
    n = 0;
    do begin
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!frame_done && n < 3000);
    pix_ready = 1'b1;
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_timeout: got no frame_done want 1 in %0d", n);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    repeat (3) begin
      tick();
      chk("reset_out",
          64'({busy, frame_done, rden, pix_valid, pix_sof, pix_eol,
               rdaddress, pix_y, pix_u, pix_v}), 64'd0);
    end
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      chk("idle_out",
          64'({busy, frame_done, rden, pix_valid, pix_sof, pix_eol,
               rdaddress, pix_y, pix_u, pix_v}), 64'd0);
    end

    // First frame, consumer always ready.
    pix_ready = 1'b1;
    all_ready = 1'b1;
    pulse_start();
    chk("busy_start", 64'(busy), 64'd1);
    chk("e0_rden", 64'(rden), 64'd1);
    chk("e0_addr", 64'(rdaddress), 64'd0);
    tick();
    chk("e1_addr", 64'(rdaddress), 64'd1);
    tick();
    chk("e2_addr", 64'(rdaddress), 64'd16);
    tick();
    chk("e3_addr", 64'(rdaddress), 64'd20);
    tick();
    chk("e4_valid", 64'(pix_valid), 64'd0);
    tick();
    chk("first_pix", 64'({pix_valid, pix_sof, pix_y, pix_u, pix_v}),
        64'({1'b1, 1'b1, 8'h00, 8'h80, 8'hA0}));
    tick();
    chk("second_pix", 64'({pix_valid, pix_sof, pix_y, pix_u, pix_v}),
        64'({1'b1, 1'b0, 8'h01, 8'h80, 8'hA0}));
    run_frame(1'b0);
    chk("row1_u_reuse", 64'(rd_log[10]), 64'd16);
    chk("row1_v_reuse", 64'(rd_log[11]), 64'd20);
    chk("row2_y0", 64'(rd_log[16]), 64'd8);
    tick();
    chk("done_pulse_1cyc", 64'(frame_done), 64'd0);

    // Random back-pressure.
    all_ready = 1'b0;
    pulse_start();
    run_frame(1'b1);

    // Start mid-frame ignored; start on frame_done accepted.
    all_ready = 1'b1;
    pulse_start();
    repeat (40) tick();
    pulse_start();
    chk("busy_midstart", 64'(busy), 64'd1);
    run_frame(1'b0);
    pulse_start();
    chk("restart_rden", 64'(rden), 64'd1);
    chk("restart_addr", 64'(rdaddress), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    run_frame(1'b0);

    // Reset during streaming, then a clean frame.
    tick();
    pulse_start();
    repeat (60) tick();
    rst_n = 1'b0;
    pix_k = 0;
    rd_k  = 0;
    #1;
    chk("abort_out",
        64'({busy, rden, pix_valid, pix_sof, pix_eol, pix_y}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    run_frame(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yuv_frame_reader.md
# yuv_frame_reader

Read-side counterpart of the camera capture path. Fetches a planar YUV 4:2:0 frame from the 64-bit frame-buffer memory, one 16-pixel group at a time (two Y words, one U word, one V word). Unpacks the bytes and emits one pixel per handshake as a Y/U/V triple with frame and line markers. Sits between the frame-buffer read port and downstream consumers such as the display, RGB conversion or the host DMA.

## Interface
- WIDTH, 640: pixels per line; must be a multiple of 16.
- HEIGHT, 480: lines per frame; must be even.
- Y_BASE, 0: word address of Y plane.
- U_BASE, WIDTH*HEIGHT/8: word address of U plane.
- V_BASE, U_BASE+WIDTH*HEIGHT/32: word address of V plane.

- CLOCK2_50  in  1  sole clock, rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to read a frame; sampled only in IDLE.
- busy  out  1  high from start acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel handshake.
- rden  out  1  memory read enable, registered.
- rdaddress  out  16  word address, registered.
- q  in  64  read data; valid exactly 1 cycle after the rden/rdaddress edge. Byte i = q[8i+7:8i] = pixel/sample i of the word.
- pix_valid  out  1  pixel present.
- pix_ready  in  1  consumer accepts; handshake = valid & ready.
- pix_y, pix_u, pix_v  out  8 each  pixel samples.
- pix_sof  out  1  qualifies pixel (0,0).
- pix_eol  out  1  qualifies last pixel of each line.

## Operation
- States: IDLE, FETCH, WAIT, STREAM.
- IDLE: start=1 moves to FETCH with row=0, grp=0. busy=1.
- FETCH issues 4 reads on consecutive cycles, then moves to WAIT:
  - Y0 = Y_BASE + row*(WIDTH/8) + 2*grp
  - Y1 = Y0 + 1
  - U = U_BASE + (row>>1)*(WIDTH/16) + grp
  - V = V_BASE + (row>>1)*(WIDTH/16) + grp
- WAIT: capture the 4 words in issue order, then enter STREAM.
- STREAM, pixel c of the group (0..15):
  - pix_y = Y word c[3], byte c[2:0].
  - pix_u = U byte c[3:1]; pix_v = V byte c[3:1].
  - Each chroma sample is shared by 2 columns and 2 rows.
- Handshake: once pix_valid rises, it and all pix_* outputs stay stable until handshake. pix_ready low stalls indefinitely with no state change.
- Advance:
  - After the handshake on c=15: grp++. On grp wrap, row++ and eol has already been flagged.
  - If not the last group of the frame: go to FETCH.
  - If last pixel of the frame (row=HEIGHT-1, grp=WIDTH/16-1, c=15): go to IDLE, busy<=0, frame_done<=1 for one cycle.
- start while busy is ignored. start coincident with frame_done: frame_done is issued from IDLE, so that start is accepted.
- Address arithmetic is 16-bit unsigned; parameters must keep V_BASE+WIDTH*HEIGHT/32 ≤ 65536. No wrap checking.

## Timing
- Reset values: busy, frame_done, rden, pix_valid, pix_sof, pix_eol = 0. rdaddress and pix_y/u/v = 0.
- Reset mid-frame: immediate abort to IDLE. Any in-flight q is discarded.
- Start accepted at edge E0:
  - rden/rdaddress present Y0, Y1, U, V after E0..E3.
  - pix_valid rises after E5, i.e. 5-cycle start-to-first-pixel.
- Without prefetch, each further group costs 5 non-streaming cycles: FETCH 4 plus the last capture.
- frame_done is high in the cycle after the final handshake.

## Configuration
- YUV_READER_PREFETCH_EN defined:
  - Second group buffer; the next group's 4 reads are issued during STREAM of the current group.
  - With pix_ready held at 1, the stream is gapless: one pixel per cycle across groups and lines.
  - Prefetch is suppressed after the last group.
- Undefined: single buffer, behaviour as in Operation and Timing.

## Structure
- Package yuv_reader_pkg:
  - State enum.
  - GROUP_PIX=16, WORDS_PER_GROUP=4.
  - Default base-address functions of WIDTH/HEIGHT.
- Sub-module yuv_group_buffer:
  - Captures Y0/Y1/U/V words by index.
  - Selects bytes for column c.
  - Instantiated twice under YUV_READER_PREFETCH_EN.

## Test plan
All scenarios use WIDTH=32, HEIGHT=4 and a memory model with 1-cycle latency returning byte i of word A = (A*8+i) mod 256.
- Reset release, no start -> all outputs 0, rden never asserted.
- start, pix_ready=1 -> rdaddress sequence 0,1,16,20 after E0..E3. First pixel after E5: y=0x00, u=0x80, v=0xA0, sof=1. Second pixel: y=0x01, u=0x80, v=0xA0.
- Full frame, pix_ready=1 -> 128 handshakes. eol on pixels 31/63/95/127. Row 1 reuses the chroma addresses of row 0. frame_done one cycle after pixel 127, busy then 0.
- pix_ready toggled pseudo-randomly -> pix_* never changes while valid & !ready. Pixel sequence identical to the ready=1 run.
- start pulsed mid-frame, and start coincident with frame_done -> first ignored, second begins a new frame with rdaddress=0.
- RESET_N low during STREAM, then start -> clean restart at pixel (0,0). With YUV_READER_PREFETCH_EN: no pix_valid gaps across the frame.
